// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------------------
// dds_pkg
//   Shared definitions for the DDS waveform generator.
//   - wave_e      : waveform select codes (sine / square / triangle)
//   - wave_valid  : 1 when a 3-bit select code is one of the three waveforms
//   - mid_of      : offset-binary midscale for a given sample width
//   - *_DEF / MID : default widths and the default midscale value
// ---------------------------------------------------------------------------
package dds_pkg;

  typedef enum logic [2:0] {
    WAVE_TRI    = 3'b011,
    WAVE_SQUARE = 3'b101,
    WAVE_SINE   = 3'b110
  } wave_e;

  localparam int PHASE_W_DEF = 32;
  localparam int ADDR_W_DEF  = 10;
  localparam int DATA_W_DEF  = 10;

  function automatic int mid_of(input int w);
    return 1 << (w - 1);
  endfunction

  localparam int MID = mid_of(DATA_W_DEF);

  function automatic logic wave_valid(input logic [2:0] code);
    return (code == WAVE_SINE) || (code == WAVE_SQUARE) || (code == WAVE_TRI);
  endfunction

endpackage

// File: rtl/dds_wave_gen_if.sv
// ---------------------------------------------------------------------------
// dds_wave_gen_if
//   Control inputs from the frequency/waveform controller and the parallel
//   DAC outputs of the DDS core.
//   Control : en, fre_k[PHASE_W], sel_wave[3]
//   DAC     : dac_data[DATA_W], dac_valid, wrap_pulse, sel_active[3]
//   modport master : controller / DAC side (drives control, reads DAC bus)
//   modport slave  : DDS core side (reads control, drives DAC bus)
//
//   Handshake: dac_valid qualifies dac_data, wrap_pulse and sel_active in the
//   same cycle. There is no ready; the sink must accept every valid sample.
//   While dac_valid is low, dac_data holds the last live sample.
// ---------------------------------------------------------------------------
interface dds_wave_gen_if #(
  parameter int PHASE_W = 32,
  parameter int DATA_W  = 10
);
  logic               en;
  logic [PHASE_W-1:0] fre_k;
  logic [2:0]         sel_wave;
  logic [DATA_W-1:0]  dac_data;
  logic               dac_valid;
  logic               wrap_pulse;
  logic [2:0]         sel_active;

  modport master (
    output en, fre_k, sel_wave,
    input  dac_data, dac_valid, wrap_pulse, sel_active
  );

  modport slave (
    input  en, fre_k, sel_wave,
    output dac_data, dac_valid, wrap_pulse, sel_active
  );
endinterface

// File: rtl/sine_qrom.sv
// ---------------------------------------------------------------------------
// sine_qrom
//   Quarter-wave sine magnitude table, synchronous read.
//   Entry i = round((2^DW-1) * sin(pi/2 * i/(2^AW-1))), so entry 0 is 0 and
//   the last entry is full scale; the mirrored quarters then hit the exact
//   peak and trough codes.
//   The table is a constant computed at elaboration.
//   Ports: clk, rst_n (async, active-low), addr[AW] in, data[DW] out (1 clk).
// ---------------------------------------------------------------------------
module sine_qrom #(
  parameter int AW = 8,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);
  localparam int DEPTH = 1 << AW;

  function automatic logic [DW-1:0] qsin(input int i);
    real amp;
    real ang;
    amp = real'((1 << DW) - 1);
    ang = 1.5707963267948966 * real'(i) / real'(DEPTH - 1);
    return DW'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [DW-1:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = qsin(g);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data <= '0;
    else        data <= rom[addr];
  end
endmodule

// File: rtl/dds_wave_gen.sv
// ---------------------------------------------------------------------------
// dds_wave_gen
//   DDS core: phase accumulator, glitch-free waveform select, phase decode,
//   quarter-wave sine ROM and registered output mux feeding a parallel DAC.
//   Ports:
//     clk    - system clock
//     rst_n  - asynchronous reset, active-low
//     bus    - dds_wave_gen_if.slave (en, fre_k, sel_wave in;
//              dac_data, dac_valid, wrap_pulse, sel_active out)
//   Pipeline: S0 acc register -> S1 decode -> S2 ROM -> S3 output register.
//   A sample taken from acc appears on dac_data 3 clocks later, carrying its
//   own wrap flag and waveform code.
// ---------------------------------------------------------------------------
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input logic           clk,
  input logic           rst_n,
  dds_wave_gen_if.slave bus
);
  localparam logic [DATA_W-1:0] MID_L = DATA_W'(mid_of(DATA_W));

  // ---------------- S0: accumulator and select ----------------
  logic [PHASE_W-1:0] acc;
  logic               wrap_q;    // acc was reached through a carry
  logic [PHASE_W:0]   sum;
  logic [2:0]         pending;
  logic [2:0]         applied;
  logic               apply_now;

  assign sum = {1'b0, acc} + {1'b0, bus.fre_k};

  // wrap_q holds while frozen so a wrap just before en falls is still
  // reported on that sample once it is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      wrap_q <= 1'b0;
    end else if (bus.en) begin
      acc    <= sum[PHASE_W-1:0];
      wrap_q <= sum[PHASE_W];
    end
  end

  // The new code may only reach the output at a period boundary, or when
  // the phase is not moving (no wrap will ever come).
  assign apply_now = (bus.en && sum[PHASE_W]) || !bus.en || (bus.fre_k == '0);

  // applied takes the old pending value, so a code arriving in the wrap
  // cycle itself waits for the following wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= WAVE_SINE;
      applied <= WAVE_SINE;
    end else begin
      if (wave_valid(bus.sel_wave)) pending <= bus.sel_wave;
      if (apply_now)                applied <= pending;
    end
  end

  // ---------------- S1: phase decode ----------------
  logic [ADDR_W-1:0] p;
  logic [1:0]        q;
  logic [ADDR_W-3:0] idx;

  assign p   = acc[PHASE_W-1 -: ADDR_W];
  assign q   = p[ADDR_W-1:ADDR_W-2];
  assign idx = q[0] ? ~p[ADDR_W-3:0] : p[ADDR_W-3:0];

  logic              s1_valid, s1_wrap, s1_q1, s1_msb;
  logic [2:0]        s1_sel;
  logic [ADDR_W-3:0] s1_idx;
  logic [DATA_W-1:0] s1_tri;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_wrap  <= 1'b0;
      s1_q1    <= 1'b0;
      s1_msb   <= 1'b0;
      s1_sel   <= WAVE_SINE;
      s1_idx   <= '0;
      s1_tri   <= '0;
    end else begin
      s1_valid <= bus.en;
      s1_wrap  <= wrap_q;
      s1_q1    <= q[1];
      s1_msb   <= acc[PHASE_W-1];
      s1_sel   <= applied;
      s1_idx   <= idx;
      s1_tri   <= acc[PHASE_W-2 -: DATA_W];
    end
  end

  // ---------------- S2: ROM read ----------------
  logic [DATA_W-2:0] rom_a;

  sine_qrom #(
    .AW(ADDR_W - 2),
    .DW(DATA_W - 1)
  ) u_rom (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (s1_idx),
    .data (rom_a)
  );

  logic              s2_valid, s2_wrap, s2_q1, s2_msb;
  logic [2:0]        s2_sel;
  logic [DATA_W-1:0] s2_tri;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_wrap  <= 1'b0;
      s2_q1    <= 1'b0;
      s2_msb   <= 1'b0;
      s2_sel   <= WAVE_SINE;
      s2_tri   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_wrap  <= s1_wrap;
      s2_q1    <= s1_q1;
      s2_msb   <= s1_msb;
      s2_sel   <= s1_sel;
      s2_tri   <= s1_tri;
    end
  end

  // ---------------- S3: output mux ----------------
  logic [DATA_W-1:0] mux_out;

  always_comb begin
    mux_out = MID_L;
    case (s2_sel)
      WAVE_SINE:   mux_out = s2_q1 ? (MID_L - DATA_W'(1) - {1'b0, rom_a})
                                   : (MID_L + {1'b0, rom_a});
      WAVE_SQUARE: mux_out = s2_msb ? '0 : '1;
      WAVE_TRI:    mux_out = s2_msb ? ~s2_tri : s2_tri;
      default:     mux_out = MID_L;
    endcase
  end

  logic [DATA_W-1:0] dac_data_q;
  logic              dac_valid_q, wrap_pulse_q;
  logic [2:0]        sel_active_q;

  // dac_data and sel_active only move on a live sample, so they hold the
  // last value while the phase is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_data_q   <= MID_L;
      dac_valid_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      sel_active_q <= WAVE_SINE;
    end else if (s2_valid) begin
      dac_data_q   <= mux_out;
      dac_valid_q  <= 1'b1;
      wrap_pulse_q <= s2_wrap;
      sel_active_q <= s2_sel;
    end else begin
      dac_valid_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end
  end

  assign bus.dac_data   = dac_data_q;
  assign bus.dac_valid  = dac_valid_q;
  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.sel_active = sel_active_q;

endmodule
